stack_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the circular LIFO `stack`, turning Forth-style stack operations into that block's push/pop/data_in strobes. It caches the top of stack (TOS) in a local register, tracks depth, and optionally detects overflow and underflow. It serves the data and return stacks of the 18-bit core: core → `stack_ctrl` → `stack`.

---
 rtl/stack_ctrl_pkg.sv | 28 ++
 rtl/stack_ctrl.sv | 156 +++++++++++++++
 tb/tb_stack_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared types for the stack command sequencer: op encoding, FSM states and
// the capacity helper (memory depth plus the cached TOS word).
package stack_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_DROP = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP_WAIT,
        S_OVER_A,
        S_OVER_B
    } state_t;

    function automatic int calc_capacity(input int stack_size);
        return (1 << stack_size) + 1;
    endfunction

    localparam int DEF_STACK_SIZE = 1;
    localparam int CAPACITY       = calc_capacity(DEF_STACK_SIZE);

endpackage

// File: rtl/stack_ctrl.sv
// Forth-style command sequencer in front of the circular LIFO `stack`; caches TOS.
// Define STACK_CTRL_CHECK_EN to enable sticky overflow/underflow detection.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int STACK_WIDTH = 18,
    parameter int STACK_SIZE  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [STACK_WIDTH-1:0] cmd_data,
    output logic [STACK_WIDTH-1:0] tos,
    output logic [STACK_SIZE:0]    depth,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic [STACK_WIDTH-1:0] stk_din,
    input  logic [STACK_WIDTH-1:0] stk_dout,
    output logic                   err_ovf,
    output logic                   err_unf
);

    localparam int            DW  = STACK_SIZE + 1;
    localparam logic [DW-1:0] CAP = DW'(calc_capacity(STACK_SIZE));
    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] TWO = DW'(2);

    state_t                 r_state;
    logic [STACK_WIDTH-1:0] r_tos, r_tmp;
    logic [DW-1:0]          r_depth;

    logic w_chk, w_idle_cmd, w_go, w_ovf, w_unf, w_full, w_empty, w_lt2;
    logic w_push, w_pop;
    logic [STACK_WIDTH-1:0] w_din;

`ifdef STACK_CTRL_CHECK_EN
    assign w_chk = 1'b1;
`else
    assign w_chk = 1'b0;
`endif

    assign w_idle_cmd = cmd_valid && (r_state == S_IDLE);
    assign w_full     = (r_depth >= CAP);
    assign w_empty    = (r_depth == '0);
    assign w_lt2      = (r_depth < TWO);

    always_comb begin
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (w_idle_cmd) begin
            case (cmd_op)
                OP_PUSH: w_ovf = w_full;
                OP_DUP:  begin w_ovf = w_full; w_unf = w_empty; end
                OP_DROP: w_unf = w_empty;
                OP_SWAP: w_unf = w_lt2;
                OP_OVER: begin w_ovf = w_full; w_unf = w_lt2; end
                default: ;
            endcase
        end
    end

    // A rejected command is still accepted; it just behaves as a NOP.
    assign w_go = w_idle_cmd && !(w_chk && (w_ovf || w_unf));

    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_din  = '0;
        case (r_state)
            S_IDLE: if (w_go) begin
                case (cmd_op)
                    OP_PUSH: if (!w_empty) begin w_push = 1'b1; w_din = r_tos; end
                    OP_DUP:  begin w_push = 1'b1; w_din = r_tos; end
                    OP_DROP: w_pop = (r_depth != ONE);
                    OP_SWAP: begin w_push = 1'b1; w_pop = 1'b1; w_din = r_tos; end
                    OP_OVER: w_pop = 1'b1;
                    default: ;
                endcase
            end
            S_OVER_A: begin w_push = 1'b1; w_din = stk_dout; end
            S_OVER_B: begin w_push = 1'b1; w_din = r_tos; end
            default: ;
        endcase
        if (reset) begin
            w_push = 1'b0;
            w_pop  = 1'b0;
            w_din  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tos   <= '0;
            r_tmp   <= '0;
            r_depth <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    case (cmd_op)
                        OP_PUSH: begin r_tos <= cmd_data; r_depth <= r_depth + ONE; end
                        OP_DUP:  r_depth <= r_depth + ONE;
                        OP_DROP: begin
                            if (r_depth == ONE) begin
                                r_tos   <= '0;
                                r_depth <= '0;
                            end else begin
                                r_depth <= r_depth - ONE;
                                r_state <= S_POP_WAIT;
                            end
                        end
                        OP_SWAP: r_state <= S_POP_WAIT;
                        OP_OVER: r_state <= S_OVER_A;
                        default: ;
                    endcase
                end
                S_POP_WAIT: begin r_tos <= stk_dout; r_state <= S_IDLE; end
                S_OVER_A:   begin r_tmp <= stk_dout; r_state <= S_OVER_B; end
                S_OVER_B: begin
                    r_tos   <= r_tmp;
                    r_depth <= r_depth + ONE;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef STACK_CTRL_CHECK_EN
    logic r_err_ovf, r_err_unf;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | w_ovf;
            r_err_unf <= r_err_unf | w_unf;
        end
    end
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign tos       = r_tos;
    assign depth     = r_depth;
    assign stk_push  = w_push;
    assign stk_pop   = w_pop;
    assign stk_din   = w_din;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl paired with a behavioural circular LIFO; per-command
// expectations are queued at issue and checked when the controller is idle again.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [17:0] cmd_data = '0;
    logic [17:0] tos, stk_din, stk_dout;
    logic [2:0]  depth;
    logic        stk_push, stk_pop, err_ovf, err_unf;

    int n_chk = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_pop = 0;

    typedef struct {
        string       tag;
        logic [17:0] tos;
        logic [2:0]  depth;
        int          occ;
        int          npush;
        int          npop;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] din_q[$];

    always #5 clk = ~clk;

    stack_ctrl #(.STACK_WIDTH(18), .STACK_SIZE(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .tos(tos), .depth(depth),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    // Behavioural model of the paired circular LIFO (4 words).
    logic [17:0] m_mem [4];
    logic [1:0]  m_ptr;
    always @(posedge clk) begin
        if (reset) begin
            m_ptr    <= '0;
            stk_dout <= '0;
            for (int i = 0; i < 4; i++) m_mem[i] <= '0;
        end else if (stk_push && stk_pop) begin
            stk_dout       <= m_mem[m_ptr];
            m_mem[m_ptr]   <= stk_din;
        end else if (stk_push) begin
            m_ptr                <= m_ptr + 2'd1;
            m_mem[m_ptr + 2'd1]  <= stk_din;
        end else if (stk_pop) begin
            stk_dout <= m_mem[m_ptr];
            m_ptr    <= m_ptr - 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stk_push) begin
            n_push++;
            if (din_q.size() == 0) chk("stk_din_unexpected", 32'(stk_din), 32'hFFFF_FFFF);
            else                   chk("stk_din", 32'(stk_din), 32'(din_q.pop_front()));
        end
        if (stk_pop) n_pop++;
    end

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [17:0] d,
                           input logic [17:0] etos, input logic [2:0] edep,
                           input int eocc, input int epush, input int epop);
        exp_t e;
        int   occ, p0, q0;
        e.tag = tag; e.tos = etos; e.depth = edep;
        e.occ = eocc; e.npush = epush; e.npop = epop;
        exp_q.push_back(e);
        p0 = n_push;
        q0 = n_pop;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0;
        occ = 1;
        forever begin
            @(negedge clk);
            if (cmd_ready || occ > 8) break;
            occ++;
        end
        e = exp_q.pop_front();
        chk({e.tag, "_tos"},   32'(tos),          32'(e.tos));
        chk({e.tag, "_depth"}, 32'(depth),        32'(e.depth));
        chk({e.tag, "_occ"},   32'(occ),          32'(e.occ));
        chk({e.tag, "_npush"}, 32'(n_push - p0),  32'(e.npush));
        chk({e.tag, "_npop"},  32'(n_pop - q0),   32'(e.npop));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_push_in_reset", 32'(stk_push), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_tos",   32'(tos),       32'd0);
        chk("rst_depth", 32'(depth),     32'd0);
        chk("rst_push",  32'(stk_push),  32'd0);
        chk("rst_pop",   32'(stk_pop),   32'd0);
        chk("rst_din",   32'(stk_din),   32'd0);
        chk("rst_ovf",   32'(err_ovf),   32'd0);
        chk("rst_unf",   32'(err_unf),   32'd0);

        run_cmd("push11", OP_PUSH, 18'h11, 18'h11, 3'd1, 1, 0, 0);
        din_q.push_back(18'h11);
        run_cmd("push22", OP_PUSH, 18'h22, 18'h22, 3'd2, 1, 1, 0);
        din_q.push_back(18'h22);
        run_cmd("push33", OP_PUSH, 18'h33, 18'h33, 3'd3, 1, 1, 0);
        din_q.push_back(18'h33);
        run_cmd("swap",   OP_SWAP, 18'h0,  18'h22, 3'd3, 2, 1, 1);
        run_cmd("drop1",  OP_DROP, 18'h0,  18'h33, 3'd2, 2, 0, 1);
        din_q.push_back(18'h11);
        din_q.push_back(18'h33);
        run_cmd("over",   OP_OVER, 18'h0,  18'h11, 3'd3, 3, 2, 1);
        run_cmd("drop2",  OP_DROP, 18'h0,  18'h33, 3'd2, 2, 0, 1);
        run_cmd("drop3",  OP_DROP, 18'h0,  18'h11, 3'd1, 2, 0, 1);
        run_cmd("drop4",  OP_DROP, 18'h0,  18'h00, 3'd0, 1, 0, 0);

`ifdef STACK_CTRL_CHECK_EN
        do_reset();
        run_cmd("cpush1", OP_PUSH, 18'd1, 18'd1, 3'd1, 1, 0, 0);
        for (int i = 2; i <= 5; i++) begin
            din_q.push_back(18'(i - 1));
            run_cmd("cpush", OP_PUSH, 18'(i), 18'(i), 3'(i), 1, 1, 0);
        end
        run_cmd("cpush6", OP_PUSH, 18'd6, 18'd5, 3'd5, 1, 0, 0);
        chk("ovf_set",   32'(err_ovf), 32'd1);
        chk("ovf_unf0",  32'(err_unf), 32'd0);
        do_reset();
        chk("ovf_clr",   32'(err_ovf), 32'd0);
        run_cmd("cdrop0", OP_DROP, 18'd0, 18'd0, 3'd0, 1, 0, 0);
        chk("unf_set",   32'(err_unf), 32'd1);
`else
        do_reset();
        run_cmd("wdrop0", OP_DROP, 18'd0, 18'd0, 3'd7, 2, 0, 1);
        chk("wrap_ovf",  32'(err_ovf), 32'd0);
        chk("wrap_unf",  32'(err_unf), 32'd0);
`endif

        do_reset();
        run_cmd("pushA", OP_PUSH, 18'h0A, 18'h0A, 3'd1, 1, 0, 0);
        din_q.push_back(18'h0A);
        run_cmd("pushB", OP_PUSH, 18'h0B, 18'h0B, 3'd2, 1, 1, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = OP_OVER;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_push", 32'(stk_push), 32'd0);
        chk("midrst_pop",  32'(stk_pop),  32'd0);
        chk("midrst_din",  32'(stk_din),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_tos",   32'(tos),       32'd0);
        chk("midrst_depth", 32'(depth),     32'd0);
        chk("midrst_push2", 32'(stk_push),  32'd0);
        run_cmd("pushmax", OP_PUSH, 18'h3FFFF, 18'h3FFFF, 3'd1, 1, 0, 0);
        din_q.push_back(18'h3FFFF);
        run_cmd("dup",     OP_DUP,  18'h0,     18'h3FFFF, 3'd2, 1, 1, 0);
        run_cmd("nop7",    3'd7,    18'h155,   18'h3FFFF, 3'd2, 1, 0, 0);

        chk("din_q_left", 32'(din_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
